// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared address map, target/state enums and range helpers for the data-bus bridge
package bridge_pkg;

    localparam logic [31:0] DM_LO        = 32'h0000_0000;
    localparam logic [31:0] DM_HI        = 32'h0000_2FFF;
    localparam logic [31:0] TC0_BASE     = 32'h0000_7F00;
    localparam logic [31:0] TC1_BASE     = 32'h0000_7F10;
    localparam logic [31:0] TC_COUNT_OFS = 32'h0000_0008;
    localparam logic [31:0] TC_SPAN      = 32'h0000_000C;
    localparam logic [31:0] INT_ACK_BASE = 32'h0000_7F20;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        DM     = 3'd1,
        TC0    = 3'd2,
        TC1    = 3'd3,
        INTACK = 3'd4
    } target_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Inclusive range test written as an unsigned offset compare so that
    // addresses below lo wrap to large values and fall out of range.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr - lo) <= (hi - lo);
    endfunction

    // Any byte of a timer's register block (control, preset, count).
    function automatic logic tc_hit(input logic [31:0] addr, input logic [31:0] base);
        return in_range(addr, base, base + TC_SPAN - 32'd1);
    endfunction

    // The read-only count register of a timer block.
    function automatic logic tc_count_hit(input logic [31:0] addr, input logic [31:0] base);
        return in_range(addr, base + TC_COUNT_OFS, base + TC_SPAN - 32'd1);
    endfunction

endpackage

// File: rtl/bridge_decode.sv
// rtl/bridge_decode.sv - combinational target decode and access-legality check
//
// Ports:
//   addr_i    byte address of the access
//   we_i      1 = write, 0 = read
//   byteen_i  lane-aligned byte enables
//   target_o  decoded target (bridge_pkg::target_e encoding)
//   err_o     1 = access must be rejected without reaching a target
module bridge_decode
    import bridge_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  byteen_i,
    output logic [2:0]  target_o,
    output logic        err_o
);

    target_e tgt;
    logic    is_tc;
    logic    count_hit;

    always_comb begin
        tgt = NONE;
        if (in_range(addr_i, DM_LO, DM_HI)) begin
            tgt = DM;
        end else if (tc_hit(addr_i, TC0_BASE)) begin
            tgt = TC0;
        end else if (tc_hit(addr_i, TC1_BASE)) begin
            tgt = TC1;
        end else if (in_range(addr_i, INT_ACK_BASE, INT_ACK_BASE + 32'd3)) begin
            tgt = INTACK;
        end
    end

    assign is_tc     = (tgt == TC0) || (tgt == TC1);
    assign count_hit = tc_count_hit(addr_i, TC0_BASE) || tc_count_hit(addr_i, TC1_BASE);

    // Timers are word-only registers and their count is read-only; the
    // interrupt-acknowledge register is write-only.
    assign err_o = (tgt == NONE)
                || (byteen_i == 4'b0000)
                || (is_tc && (byteen_i != 4'b1111))
                || (is_tc && we_i && count_hit)
                || ((tgt == INTACK) && !we_i);

    assign target_o = tgt;

endmodule

// File: rtl/bridge_arbiter.sv
// rtl/bridge_arbiter.sv - two-master arbiter and sequencer for the DM / timer / int-ack port
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   m0_* / m1_*                    master request, command fields, done/err pulses
//   m_rdata                        read data of the last completed read (shared)
//   dm_addr/dm_byteen/dm_wdata     DM command; dm_rdata is synchronous read data
//   tc0_we/tc1_we/tc_addr/tc_wdata timer register write port; tc0/tc1_rdata combinational
//   int_ack                        one-cycle pulse on a write to the int-ack register
module bridge_arbiter
    import bridge_pkg::*;
#(
    parameter logic RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m0_byteen,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_done,
    output logic        m1_done,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] m_rdata,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_byteen,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    output logic        tc0_we,
    output logic        tc1_we,
    output logic [29:0] tc_addr,
    output logic [31:0] tc_wdata,
    input  logic [31:0] tc0_rdata,
    input  logic [31:0] tc1_rdata,
    output logic        int_ack
);

    state_e      state_q;
    logic        last_q;
    logic        owner_q;
    logic        we_q;
    target_e     tgt_q;
    logic        derr_q;
    logic [31:0] dm_addr_q;
    logic [3:0]  dm_byteen_q;
    logic [31:0] dm_wdata_q;
    logic [29:0] tc_addr_q;
    logic [31:0] tc_wdata_q;
    logic        tc0_we_q;
    logic        tc1_we_q;
    logic        int_ack_q;
    logic        m0_done_q;
    logic        m1_done_q;
    logic        m0_err_q;
    logic        m1_err_q;
    logic [31:0] m_rdata_q;

    logic        grant_d;
    logic        sel_we_d;
    logic [31:0] sel_addr_d;
    logic [3:0]  sel_byteen_d;
    logic [31:0] sel_wdata_d;
    logic [31:0] rdata_d;
    logic [2:0]  dec_target;
    logic        dec_err;
    target_e     dec_tgt;

    // Winner selection; only consumed in IDLE. On a tie, round-robin picks
    // the master that did not win last.
    always_comb begin
        grant_d = 1'b0;
        if (m0_req && m1_req) begin
            grant_d = RR_EN ? ~last_q : 1'b0;
        end else if (m1_req) begin
            grant_d = 1'b1;
        end
        sel_we_d     = grant_d ? m1_we     : m0_we;
        sel_addr_d   = grant_d ? m1_addr   : m0_addr;
        sel_byteen_d = grant_d ? m1_byteen : m0_byteen;
        sel_wdata_d  = grant_d ? m1_wdata  : m0_wdata;
    end

    bridge_decode u_decode (
        .addr_i   (sel_addr_d),
        .we_i     (sel_we_d),
        .byteen_i (sel_byteen_d),
        .target_o (dec_target),
        .err_o    (dec_err)
    );

    assign dec_tgt = target_e'(dec_target);

    always_comb begin
        rdata_d = dm_rdata;
        case (tgt_q)
            TC0:     rdata_d = tc0_rdata;
            TC1:     rdata_d = tc1_rdata;
            default: rdata_d = dm_rdata;
        endcase
    end

    // Strobes and done/err are registered: they are loaded on the edge that
    // enters ISSUE/DONE and cleared by default on every other edge, so each
    // is a single-cycle pulse aligned with its state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            tgt_q       <= NONE;
            derr_q      <= 1'b0;
            dm_addr_q   <= '0;
            dm_byteen_q <= '0;
            dm_wdata_q  <= '0;
            tc_addr_q   <= '0;
            tc_wdata_q  <= '0;
            tc0_we_q    <= 1'b0;
            tc1_we_q    <= 1'b0;
            int_ack_q   <= 1'b0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
            m_rdata_q   <= '0;
        end else begin
            dm_byteen_q <= 4'b0000;
            tc0_we_q    <= 1'b0;
            tc1_we_q    <= 1'b0;
            int_ack_q   <= 1'b0;
            m0_done_q   <= 1'b0;
            m1_done_q   <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner_q    <= grant_d;
                        last_q     <= grant_d;
                        we_q       <= sel_we_d;
                        tgt_q      <= dec_tgt;
                        derr_q     <= dec_err;
                        dm_addr_q  <= sel_addr_d;
                        tc_addr_q  <= sel_addr_d[31:2];
                        dm_wdata_q <= sel_wdata_d;
                        tc_wdata_q <= sel_wdata_d;
                        if (sel_we_d && !dec_err) begin
                            case (dec_tgt)
                                DM:      dm_byteen_q <= sel_byteen_d;
                                TC0:     tc0_we_q    <= 1'b1;
                                TC1:     tc1_we_q    <= 1'b1;
                                INTACK:  int_ack_q   <= 1'b1;
                                default: ;
                            endcase
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!derr_q && !we_q) begin
                        state_q <= WAIT;
                    end else begin
                        state_q   <= DONE;
                        m0_done_q <= ~owner_q;
                        m1_done_q <= owner_q;
                        m0_err_q  <= derr_q & ~owner_q;
                        m1_err_q  <= derr_q & owner_q;
                    end
                end
                WAIT: begin
                    m_rdata_q <= rdata_d;
                    m0_done_q <= ~owner_q;
                    m1_done_q <= owner_q;
                    state_q   <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m0_done   = m0_done_q;
    assign m1_done   = m1_done_q;
    assign m0_err    = m0_err_q;
    assign m1_err    = m1_err_q;
    assign m_rdata   = m_rdata_q;
    assign dm_addr   = dm_addr_q;
    assign dm_byteen = dm_byteen_q;
    assign dm_wdata  = dm_wdata_q;
    assign tc0_we    = tc0_we_q;
    assign tc1_we    = tc1_we_q;
    assign tc_addr   = tc_addr_q;
    assign tc_wdata  = tc_wdata_q;
    assign int_ack   = int_ack_q;

endmodule

// File: tb/tb_bridge_arbiter.sv
// tb/tb_bridge_arbiter.sv - self-checking bench for bridge_arbiter
module tb_bridge_arbiter;

    logic        clk;
    logic        reset_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_byteen, m1_byteen;
    logic [31:0] dm_rdata, tc0_rdata, tc1_rdata;

    logic        m0_done, m1_done, m0_err, m1_err, tc0_we, tc1_we, int_ack;
    logic [31:0] m_rdata, dm_addr, dm_wdata, tc_wdata;
    logic [3:0]  dm_byteen;
    logic [29:0] tc_addr;

    logic        fp_m0_done, fp_m1_done, fp_m0_err, fp_m1_err, fp_tc0_we, fp_tc1_we, fp_int_ack;
    logic [31:0] fp_m_rdata, fp_dm_addr, fp_dm_wdata, fp_tc_wdata;
    logic [3:0]  fp_dm_byteen;
    logic [29:0] fp_tc_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    bridge_arbiter #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_byteen(m0_byteen), .m1_byteen(m1_byteen),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_done(m0_done), .m1_done(m1_done), .m0_err(m0_err), .m1_err(m1_err),
        .m_rdata(m_rdata), .dm_addr(dm_addr), .dm_byteen(dm_byteen), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .tc0_we(tc0_we), .tc1_we(tc1_we), .tc_addr(tc_addr),
        .tc_wdata(tc_wdata), .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata), .int_ack(int_ack)
    );

    bridge_arbiter #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_byteen(m0_byteen), .m1_byteen(m1_byteen),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_done(fp_m0_done), .m1_done(fp_m1_done), .m0_err(fp_m0_err), .m1_err(fp_m1_err),
        .m_rdata(fp_m_rdata), .dm_addr(fp_dm_addr), .dm_byteen(fp_dm_byteen), .dm_wdata(fp_dm_wdata),
        .dm_rdata(dm_rdata), .tc0_we(fp_tc0_we), .tc1_we(fp_tc1_we), .tc_addr(fp_tc_addr),
        .tc_wdata(fp_tc_wdata), .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata), .int_ack(fp_int_ack)
    );

    // Data memory model: synchronous read, word contents derived from the address.
    always @(posedge clk) begin
        dm_rdata <= 32'hC0DE_0000 | {16'h0000, dm_addr[15:0]};
    end

    typedef struct {
        logic        master;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
        logic [31:0] tc0_rd;
        logic [31:0] tc1_rd;
        logic [3:0]  exp_dm_be;
        logic [2:0]  exp_strb;   // {tc0_we, tc1_we, int_ack}
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic        master;
        logic        err;
        logic        rd;
        logic [31:0] rdata;
    } sb_t;

    vec_t        vecs[16];
    sb_t         sbq[$];
    sb_t         sb_e;
    logic [31:0] model_rdata;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] strobes();
        return {dm_byteen, tc0_we, tc1_we, int_ack};
    endfunction

    // Compare the completion on the bus against the oldest expected entry.
    task automatic sb_pop_check(input string tag);
        if (sbq.size() == 0) begin
            check({tag, "_unexpected_done"}, {m1_done, m0_done}, 2'b00);
        end else begin
            sb_e = sbq.pop_front();
            check({tag, "_done_master"}, {m1_done, m0_done}, sb_e.master ? 2'b10 : 2'b01);
            check({tag, "_err"}, {m1_err, m0_err},
                  sb_e.err ? (sb_e.master ? 2'b10 : 2'b01) : 2'b00);
            if (sb_e.rd) model_rdata = sb_e.rdata;
            check({tag, "_rdata"}, m_rdata, model_rdata);
        end
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_byteen = '0; m1_byteen = '0;
        m0_wdata = '0; m1_wdata = '0;
    endtask

    task automatic drive_master(input logic m, input logic we, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd);
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_byteen = be; m1_wdata = wd;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_byteen = be; m0_wdata = wd;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        model_rdata = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   lat;
        logic quiet;
        string tag;
        tag = $sformatf("v%0d", idx);
        tc0_rdata = v.tc0_rd;
        tc1_rdata = v.tc1_rd;
        drive_master(v.master, v.we, v.addr, v.byteen, v.wdata);
        sbq.push_back('{v.master, v.exp_err, !v.we && !v.exp_err, v.exp_rdata});
        step();
        check({tag, "_strobe_c1"}, strobes(), {v.exp_dm_be, v.exp_strb});
        check({tag, "_addr_c1"}, {dm_addr, tc_addr}, {v.addr, v.addr[31:2]});
        if (v.we) check({tag, "_wdata_c1"}, {dm_wdata, tc_wdata}, {v.wdata, v.wdata});
        lat = 0;
        quiet = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            step();
            if (strobes() != 7'd0) quiet = 1'b0;
            if (m0_done || m1_done) begin
                lat = c;
                sb_pop_check(tag);
                break;
            end
        end
        check({tag, "_latency"}, lat, (!v.we && !v.exp_err) ? 3 : 2);
        check({tag, "_strobe_quiet"}, quiet, 1'b1);
        step();
        check({tag, "_no_regrant"}, {strobes(), m0_done, m1_done}, 9'd0);
        if (v.master) m1_req = 1'b0; else m0_req = 1'b0;
        step();
        check({tag, "_no_done_after"}, {m0_done, m1_done}, 2'b00);
    endtask

    initial begin
        int   n, n0, n1, nstb;
        logic quiet;
        n_checks = 0;
        n_fail = 0;
        model_rdata = '0;
        tc0_rdata = '0;
        tc1_rdata = '0;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0100, 4'hF, 32'h1234_5678, 32'h0, 32'h0, 4'hF, 3'b000, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_7F04, 4'hF, 32'h0, 32'hA5A5_0001, 32'h0BAD_0BAD, 4'h0, 3'b000, 1'b0, 32'hA5A5_0001};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_7F08, 4'hF, 32'h0000_0001, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_7F00, 4'h3, 32'h0000_0002, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_4000, 4'hF, 32'h0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_7F20, 4'hF, 32'h0000_0001, 32'h0, 32'h0, 4'h0, 3'b001, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_7F14, 4'hF, 32'hCAFE_0006, 32'h0, 32'h0, 4'h0, 3'b010, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b0, 32'h0000_0200, 4'hF, 32'h0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b0, 32'hC0DE_0200};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_7F18, 4'hF, 32'h0, 32'h0BAD_0BAD, 32'h5555_AAAA, 4'h0, 3'b000, 1'b0, 32'h5555_AAAA};
        vecs[9]  = '{1'b0, 1'b0, 32'h0000_7F20, 4'hF, 32'h0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0};
        vecs[10] = '{1'b1, 1'b1, 32'h0000_2FFC, 4'b0100, 32'h00AB_0000, 32'h0, 32'h0, 4'b0100, 3'b000, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_3000, 4'hF, 32'h0000_0011, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 32'h0000_0040, 4'h0, 32'h0000_0022, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h0000_7F0C, 4'hF, 32'h0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_7F00, 4'h1, 32'h0, 32'h0, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0};
        vecs[15] = '{1'b0, 1'b1, 32'h0000_7F04, 4'hF, 32'h0000_0064, 32'h0, 32'h0, 4'h0, 3'b100, 1'b0, 32'h0};

        // Reset state
        idle_inputs();
        reset_n = 1'b0;
        #2;
        check("rst_outputs_during", {m0_done, m1_done, m0_err, m1_err, strobes(), m_rdata, dm_addr, tc_addr}, '0);
        step();
        step();
        reset_n = 1'b1;
        step();
        check("rst_outputs_after", {m0_done, m1_done, m0_err, m1_err, strobes(), m_rdata, dm_addr, tc_addr}, '0);

        // Round-robin with both masters holding req: grants 0,1,0,1
        drive_master(1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'h0000_0A0A);
        drive_master(1'b1, 1'b1, 32'h0000_0020, 4'hF, 32'h0000_0B0B);
        for (int k = 0; k < 4; k++) sbq.push_back('{k[0], 1'b0, 1'b0, 32'h0});
        n = 0;
        nstb = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (dm_byteen != 4'h0) begin
                check($sformatf("rr_issue%0d_addr", nstb), dm_addr, (nstb % 2 == 0) ? 32'h10 : 32'h20);
                nstb++;
            end
            if (m0_done || m1_done) begin
                sb_pop_check($sformatf("rr%0d", n));
                n++;
                if (n == 4) begin
                    idle_inputs();
                    break;
                end
            end
        end
        check("rr_grant_count", n, 4);
        step();
        step();
        step();

        // Fixed priority instance: master 0 only
        do_reset();
        drive_master(1'b0, 1'b1, 32'h0000_0030, 4'hF, 32'h0000_0C0C);
        drive_master(1'b1, 1'b1, 32'h0000_0040, 4'hF, 32'h0000_0D0D);
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (fp_m0_done) n0++;
            if (fp_m1_done) n1++;
            if (n0 == 4) break;
        end
        idle_inputs();
        check("fp_m0_grants", n0, 4);
        check("fp_m1_grants", n1, 0);
        do_reset();
        step();

        // Table of single transactions
        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

        // Reset asserted during WAIT of a read
        tc0_rdata = 32'h1111_2222;
        drive_master(1'b0, 1'b0, 32'h0000_7F04, 4'hF, 32'h0);
        step();
        step();
        check("rstmid_before", {m0_done, m1_done, strobes()}, 9'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_outputs", {m0_done, m1_done, m0_err, m1_err, strobes(), m_rdata, dm_addr, tc_addr}, '0);
        m0_req = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        model_rdata = '0;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (m0_done || m1_done || strobes() != 7'd0) quiet = 1'b0;
        end
        check("rstmid_no_done", quiet, 1'b1);
        check("rstmid_rdata", m_rdata, 32'h0);
        run_vec(100, vecs[7]);
        run_vec(101, vecs[0]);

        check("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bridge_arbiter.md
# bridge_arbiter

Two-master arbiter and sequencer for the CPU's memory-mapped data bus. It shares one data-memory and peripheral port between the CPU memory stage (master 0) and a DMA/debug master (master 1). It serialises transactions and decodes the target: DM, Timer0, Timer1, or the interrupt-acknowledge register. Illegal accesses are rejected with an error response instead of reaching a target.

## Interface
- `RR_EN`, default 1: 1 selects round-robin arbitration; 0 gives master 0 fixed priority.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` in 1 each: transaction request; the master holds it, with its command fields stable, until its `done` pulse.
- `m0_we`, `m1_we` in 1 each: 1 = write, 0 = read.
- `m0_addr`, `m1_addr` in 32 each: byte address.
- `m0_byteen`, `m1_byteen` in 4 each: byte lanes; already lane-aligned by the master.
- `m0_wdata`, `m1_wdata` in 32 each: lane-aligned write data.
- `m0_done`, `m1_done` out 1 each: one-cycle completion pulse.
- `m0_err`, `m1_err` out 1 each: valid with `done`; 1 = access rejected.
- `m_rdata` out 32: read data of the last completed read; shared by both masters and valid when `done` is high.
- `dm_addr` out 32, `dm_byteen` out 4, `dm_wdata` out 32: DM command fields.
- `dm_rdata` in 32: DM synchronous read data, valid the cycle after the address is presented.
- `tc0_we`, `tc1_we` out 1 each: timer register write strobes.
- `tc_addr` out 30: word address `addr[31:2]`.
- `tc_wdata` out 32: timer write data.
- `tc0_rdata`, `tc1_rdata` in 32 each: timer registers, combinational read.
- `int_ack` out 1: one-cycle pulse on a write to the interrupt-acknowledge register.

## Operation
- Address map:
  - DM `0x0000_0000`–`0x0000_2FFF`.
  - Timer0 `0x7F00`–`0x7F0B`.
  - Timer1 `0x7F10`–`0x7F1B`.
  - Interrupt-acknowledge `0x7F20`–`0x7F23`.
- A transaction is rejected (err=1, no target strobe) if any of the following holds:
  - the address is unmapped;
  - a timer access has `byteen` other than `4'b1111`;
  - a write targets a timer count register (`0x7F08`–`0x7F0B` or `0x7F18`–`0x7F1B`);
  - a read targets the interrupt-acknowledge register;
  - `byteen` is `0000`.
- Arbitration happens only in IDLE.
  - If one master requests, it wins.
  - If both request and `RR_EN`=1, the winner is the master that did not win last. The last-winner register resets to 1, so master 0 wins the first tie.
  - If both request and `RR_EN`=0, master 0 always wins.
- The winner's `we`, `addr`, `byteen` and `wdata`, plus the decode result, are latched at the arbitration edge. Master inputs are ignored after that edge.
- FSM states:
  - IDLE: if any `req`, latch the winner and go to ISSUE.
  - ISSUE: drive the target for exactly one cycle.
    - DM write: `dm_byteen` = latched `byteen`.
    - Timer write: `tcX_we`=1.
    - Interrupt-acknowledge write: `int_ack`=1.
    - Read: strobes stay 0 and the address is driven.
    - Next state is WAIT for a non-error read, otherwise DONE.
  - WAIT: drive `dm_addr`/`tc_addr` again. Capture the selected target read data into the `m_rdata` register at the end of the cycle. Go to DONE.
  - DONE: pulse the winner's `done`, and its `err` if rejected. Go to IDLE.
- `dm_byteen`, `tc0_we`, `tc1_we` and `int_ack` are 0 in every state except ISSUE. Address and data outputs may hold their last value.
- `m_rdata` keeps its value until the next read capture. Writes and rejected reads leave it unchanged.

## Timing
- Reset (asynchronous assert, synchronous release):
  - state IDLE;
  - all `done`, `err` and strobes 0;
  - `m_rdata` 0; `dm_addr` 0; `tc_addr` 0;
  - last-winner = 1.
- Reset asserted mid-transaction aborts it: no strobe and no `done` is produced afterwards.
- Cycle numbering: `req` is high in cycle 0 and sampled at edge 1.
  - Write: ISSUE in cycle 1 (strobe), DONE in cycle 2. Occupancy 3 cycles including the return to IDLE.
  - Read: ISSUE in cycle 1, WAIT in cycle 2, DONE in cycle 3 with `m_rdata` valid. Occupancy 4 cycles.
  - Rejected access: ISSUE in cycle 1 (no strobe), DONE in cycle 2.
- A master drops `req` in the cycle after `done`. DONE always returns to IDLE, so a `req` still high in the DONE cycle is not re-granted.
- Requests that arrive while the FSM is busy wait. There is no queue; `req` itself is the pending state.

## Structure
- Shared package `bridge_pkg` holds:
  - address-range constants (`DM_LO`/`DM_HI`, `TC0_BASE`, `TC1_BASE`, `TC_COUNT_OFS`, `INT_ACK_BASE`);
  - the target enum {NONE, DM, TC0, TC1, INTACK};
  - the state enum {IDLE, ISSUE, WAIT, DONE}.
- One combinational sub-module, `bridge_decode`, takes `addr`, `we` and `byteen` and returns target and `err`. The timer-address decode is reusable by the store-side exception logic.
- The arbitration, FSM and output registers live in `bridge_arbiter`.

## Test plan
- Master 0 writes `0x1234_5678` with `byteen` `1111` to `0x100` → `dm_byteen`=`1111` only in cycle 1; `m0_done` in cycle 2; `err`=0.
- Master 1 reads `0x7F04` while `tc0_rdata`=`0xA5A5_0001` → `tc_addr`=`0x1FC1`; `m1_done` in cycle 3; `m_rdata`=`0xA5A5_0001`.
- Both masters hold `req` continuously with `RR_EN`=1 → grants alternate 0,1,0,1; each `done` reaches the correct master. With `RR_EN`=0 → master 0 only.
- Master 0 writes `0x7F08`, writes `0x7F00` with `byteen` `0011`, and reads `0x4000` → each gets `done`+`err`=1 two cycles after the sample edge, with no strobe and `m_rdata` unchanged.
- Master 0 writes `0x7F20` → `int_ack` is high for exactly one cycle (cycle 1).
- `reset_n` is asserted during WAIT of a read → outputs are 0 immediately; after release no `done` appears and the next request is accepted from IDLE.
